fir_decim: RTL and testbench

FIR_DECIM -- requirements
Module: fir_decim

---
 rtl/fir_decim.sv | 150 +++++++++++++++
 tb/tb_fir_decim.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/fir_decim.sv
// fir_decim: decimating FIR filter.
// Accepted samples shift into a NUM_TAPS-deep delay line. Every DECIM-th
// accepted sample triggers an output. The trigger is flagged on its own edge,
// the products are registered on the next edge, and the reduced sum is
// registered into out on the edge after that, with out_valid pulsed for one
// cycle. Out therefore appears two cycles after the triggering edge.
// Optional macro FIR_DECIM_SAT_EN: saturate the shifted sum to the output
// range instead of keeping only its low DATA_WIDTH bits.
module fir_decim #(
   parameter int DATA_WIDTH      = 5,
   parameter int TAP_COEFF_WIDTH = 5,
   parameter int NUM_TAPS        = 50,
   parameter int DECIM           = 2
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic signed [DATA_WIDTH-1:0]      in,
   input  logic                              in_valid,
   input  logic signed [TAP_COEFF_WIDTH-1:0] tap_coeffs [NUM_TAPS],
   output logic signed [DATA_WIDTH-1:0]      out,
   output logic                              out_valid
);

   localparam int PROD_W  = DATA_WIDTH + TAP_COEFF_WIDTH;
   localparam int SUM_W   = PROD_W + $clog2(NUM_TAPS);
   localparam int PHASE_W = $clog2(DECIM);
   localparam int SHIFT   = TAP_COEFF_WIDTH - 1;

   logic signed [DATA_WIDTH-1:0] delay_reg [NUM_TAPS];
   logic signed [PROD_W-1:0]     prod_reg  [NUM_TAPS];
   logic [PHASE_W-1:0]           phase_reg;
   logic                         trig_reg;
   logic                         prod_valid_reg;
   logic                         trigger;
   logic signed [SUM_W-1:0]      sum;
   logic signed [DATA_WIDTH-1:0] reduced;

   // A sample that lands on the last phase completes one decimation period.
   assign trigger = in_valid && (phase_reg == PHASE_W'(DECIM - 1));

   // Delay line: newest sample enters at index 0, shifts only on accepted samples.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_TAPS; gi++) begin : g_delay
         if (gi == 0) begin : g_head
            // Head of the delay line takes the incoming sample.
            always_ff @(posedge clk) begin
               if (rst) begin
                  delay_reg[gi] <= '0;
               end else if (in_valid) begin
                  delay_reg[gi] <= in;
               end
            end
         end else begin : g_tail
            // Each later tap takes the previous tap's sample.
            always_ff @(posedge clk) begin
               if (rst) begin
                  delay_reg[gi] <= '0;
               end else if (in_valid) begin
                  delay_reg[gi] <= delay_reg[gi-1];
               end
            end
         end
      end
   endgenerate

   // Phase counter and trigger flag; both advance only on accepted samples.
   always_ff @(posedge clk) begin
      if (rst) begin
         phase_reg <= '0;
         trig_reg  <= 1'b0;
      end else begin
         trig_reg <= trigger;
         if (in_valid) begin
            if (phase_reg == PHASE_W'(DECIM - 1)) begin
               phase_reg <= '0;
            end else begin
               phase_reg <= phase_reg + PHASE_W'(1);
            end
         end
      end
   end

   // Stage 1: one registered product per tap, using the delay line that now
   // holds the triggering sample at index 0 and the current coefficients.
   generate
      for (gi = 0; gi < NUM_TAPS; gi++) begin : g_prod
         // Products are datapath only; prod_valid_reg qualifies them.
         always_ff @(posedge clk) begin
            if (trig_reg) begin
               prod_reg[gi] <= PROD_W'(tap_coeffs[gi]) * PROD_W'(delay_reg[gi]);
            end
         end
      end
   endgenerate

   // Stage 1 valid flag, cleared by reset so in-flight triggers are dropped.
   always_ff @(posedge clk) begin
      if (rst) begin
         prod_valid_reg <= 1'b0;
      end else begin
         prod_valid_reg <= trig_reg;
      end
   end

   // Full-precision sum of all products.
   always_comb begin
      sum = '0;
      for (int k = 0; k < NUM_TAPS; k++) begin
         sum = sum + SUM_W'(prod_reg[k]);
      end
   end

`ifdef FIR_DECIM_SAT_EN
   localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'(2 ** (DATA_WIDTH - 1) - 1);
   localparam logic signed [SUM_W-1:0] SAT_MIN = ~SAT_MAX;
   logic signed [SUM_W-1:0] shifted;

   // Rescale and clamp to the representable output range.
   always_comb begin
      shifted = sum >>> SHIFT;
      if (shifted > SAT_MAX) begin
         reduced = SAT_MAX[DATA_WIDTH-1:0];
      end else if (shifted < SAT_MIN) begin
         reduced = SAT_MIN[DATA_WIDTH-1:0];
      end else begin
         reduced = shifted[DATA_WIDTH-1:0];
      end
   end
`else
   // Rescale and keep the low bits (two's-complement wrap).
   always_comb begin
      reduced = DATA_WIDTH'(sum >>> SHIFT);
   end
`endif

   // Stage 2: register the reduced sum; out holds between pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         out       <= '0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= prod_valid_reg;
         if (prod_valid_reg) begin
            out <= reduced;
         end
      end
   end

endmodule

// File: tb/tb_fir_decim.sv
// tb_fir_decim: directed-vector bench for fir_decim with a scoreboard.
// The stimulus pushes the hand-computed result and due cycle of every
// trigger; a negedge monitor pops and compares whenever out_valid is seen.
module tb_fir_decim;

   localparam int DW = 5;
   localparam int CW = 5;
   localparam int NT = 50;
   localparam int DM = 2;

   logic                 clk = 1'b0;
   logic                 rst;
   logic signed [DW-1:0] in;
   logic                 in_valid;
   logic signed [CW-1:0] tap_coeffs [NT];
   logic signed [DW-1:0] out;
   logic                 out_valid;

   typedef struct {
      int    val;
      int    due;
      string name;
   } exp_t;

   exp_t sbq[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   tb_phase = 0;
   int   last_out = 0;

   // Hand-computed results for the taps0..3=15 saturation/wrap vectors.
`ifdef FIR_DECIM_SAT_EN
   int exp_pos[4] = '{15, 15, 15, 15};
   int exp_neg[4] = '{-16, -16, -16, -16};
`else
   int exp_pos[4] = '{-4, -8, -8, -8};
   int exp_neg[4] = '{2, 4, 4, 4};
`endif

   fir_decim #(
      .DATA_WIDTH(DW),
      .TAP_COEFF_WIDTH(CW),
      .NUM_TAPS(NT),
      .DECIM(DM)
   ) dut (
      .clk(clk),
      .rst(rst),
      .in(in),
      .in_valid(in_valid),
      .tap_coeffs(tap_coeffs),
      .out(out),
      .out_valid(out_valid)
   );

   always #5 clk = ~clk;

   // Edge counter used to check output latency.
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(string name, int act, int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
      end else begin
         $display("ok   %s: %0d (cycle %0d)", name, act, cyc);
      end
   endtask

   // Monitor: compare every output pulse against the scoreboard and make
   // sure out holds its value between pulses.
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         last_out = 0;
      end else if (out_valid) begin
         if (sbq.size() == 0) begin
            check("unexpected_out_valid", 1, 0);
         end else begin
            e = sbq.pop_front();
            check({e.name, "_out"}, int'(out), e.val);
            check({e.name, "_latency"}, cyc, e.due);
         end
         last_out = int'(out);
      end else begin
         checks++;
         if (int'(out) != last_out) begin
            errors++;
            $display("FAIL out_hold: got %0d expected %0d (cycle %0d)", out, last_out, cyc);
         end
      end
   end

   // One clock of stimulus; a trigger pushes its expected value due two edges later.
   task automatic step(bit r, bit v, int x, int exp_val, string name);
      rst      = r;
      in_valid = v;
      in       = DW'(x);
      @(posedge clk);
      #1;
      if (r) begin
         tb_phase = 0;
         sbq.delete();
      end else if (v) begin
         if (tb_phase == DM - 1) begin
            sbq.push_back('{exp_val, cyc + 2, name});
            tb_phase = 0;
         end else begin
            tb_phase++;
         end
      end
   endtask

   task automatic idle(int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 0, "idle");
   endtask

   task automatic do_reset();
      step(1'b1, 1'b1, 9, 0, "rst");
      step(1'b1, 1'b0, 0, 0, "rst");
   endtask

   task automatic clear_taps();
      for (int i = 0; i < NT; i++) tap_coeffs[i] = '0;
   endtask

   initial begin
      rst      = 1'b1;
      in_valid = 1'b0;
      in       = '0;
      clear_taps();

      // Reset state.
      do_reset();
      step(1'b1, 1'b0, 0, 0, "rst");
      check("reset_out", int'(out), 0);
      check("reset_out_valid", int'(out_valid), 0);

      // tap0=15, constant 8, continuous valid: 7 every 2nd cycle.
      tap_coeffs[0] = 5'sd15;
      for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 8, 7, "const8");
      idle(4);

      // taps0..3=15, constant 15: sums 450 then 900.
      do_reset();
      for (int i = 0; i < 4; i++) tap_coeffs[i] = 5'sd15;
      for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 15, exp_pos[i/2], "pos_range");
      idle(4);

      // taps0..3=15, constant -16: sums -480 then -960.
      do_reset();
      for (int i = 0; i < 8; i++) step(1'b0, 1'b1, -16, exp_neg[i/2], "neg_range");
      idle(4);

      // Gapped input, tap0=8 tap1=-8: idle samples must not enter the delay line.
      do_reset();
      clear_taps();
      tap_coeffs[0] = 5'sd8;
      tap_coeffs[1] = -5'sd8;
      step(1'b0, 1'b1, 3, 0, "gap");
      step(1'b0, 1'b0, -7, 0, "gap");
      step(1'b0, 1'b1, 5, 1, "gap_diff_a");
      step(1'b0, 1'b0, -7, 0, "gap");
      step(1'b0, 1'b1, 4, 0, "gap");
      step(1'b0, 1'b0, 9, 0, "gap");
      step(1'b0, 1'b1, 2, -1, "gap_diff_b");
      step(1'b0, 1'b0, 0, 0, "gap");
      idle(4);

      // tap0=15, in_valid toggling with in=8.
      clear_taps();
      tap_coeffs[0] = 5'sd15;
      for (int i = 0; i < 8; i++) step(1'b0, (i % 2) == 0, 8, 7, "toggle8");
      idle(4);

      // Reset one cycle after a trigger drops that output.
      step(1'b0, 1'b1, 8, 0, "rst_drop");
      step(1'b0, 1'b1, 8, 7, "rst_drop");
      step(1'b1, 1'b0, 0, 0, "rst");
      step(1'b0, 1'b0, 0, 0, "idle");
      check("rst_drop_out", int'(out), 0);
      idle(2);
      step(1'b0, 1'b1, 8, 0, "after_rst");
      idle(3);
      step(1'b0, 1'b1, 8, 7, "after_rst");
      idle(4);

      // Coefficient change between triggers takes effect on the next one.
      step(1'b0, 1'b1, 8, 0, "coef15");
      step(1'b0, 1'b1, 8, 7, "coef15");
      idle(4);
      tap_coeffs[0] = '0;
      step(1'b0, 1'b1, 13, 0, "coef0");
      step(1'b0, 1'b1, 13, 0, "coef0");
      idle(4);

      check("scoreboard_drained", sbq.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
